router_event_monitor: RTL and testbench
=======================================

# router_event_monitor

Per-port traffic profiler attached beside each router instance. It consumes the per-port event strobes a router already produces (flit/packet in/out, SMART bypass, port empty) and accumulates saturating counters over a programmable sampling window. At the end of each window it publishes a snapshot and raises a one-cycle valid. It also runs a router-level idle detector used by the simulation drain logic and by power-gating experiments.

## Interface
Parameters:
- P, 5, number of router ports.
- CNTw, 32, width of every event counter; 2..32.
- WINw, 16, width of the window length and window down-counter.
- IDLE_CYC, 8, consecutive quiet cycles before router_idle asserts; 1..255.

Ports (port i of each flattened bus occupies bits [i*CNTw +: CNTw]):
- clk  in  1  single clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- flit_wr_i  in  P  flit written into port i this cycle.
- pck_wr_i  in  P  header flit written into port i.
- flit_wr_o  in  P  flit leaving port i.
- pck_wr_o  in  P  header flit leaving port i.
- flit_in_bypassed  in  P  flit on port i took the SMART bypass.
- port_empty  in  P  port i has no pending IVC request and no outgoing flit.
- start  in  1  begin or resume sampling; pulse.
- stop  in  1  end sampling, force a final snapshot; pulse.
- clear  in  1  zero live and snapshot counters, return to IDLE; pulse.
- window_len  in  WINw  cycles per window; 0 = no automatic snapshots.
- flit_in_cnt, pck_in_cnt, flit_out_cnt, pck_out_cnt, bypass_cnt  out  P*CNTw  snapshot counters.
- snap_valid  out  1  one-cycle pulse when the snapshot buses update.
- running  out  1  high in RUN.
- router_idle  out  1  high after IDLE_CYC quiet cycles.

## Operation
- States: IDLE (reset state), RUN, SNAP.
- Control priority: clear > stop > start. Control pulses in SNAP are held off and acted on in the following cycle.
- IDLE:
  - Counters are frozen.
  - start loads win_cnt := window_len and moves to RUN.
- RUN:
  - Each asserted strobe increments its live counter by 1.
  - Counters saturate at 2^CNTw-1 and never wrap.
  - win_cnt decrements every cycle when window_len != 0.
  - When win_cnt == 1 or stop is asserted, go to SNAP.
- SNAP (1 cycle):
  - Snapshot := live counters, including the events strobed in the last RUN cycle.
  - Live counters := 0, then count the SNAP cycle's own events. No event is lost.
  - snap_valid pulses.
  - Next state is RUN with win_cnt reloaded, or IDLE if the entry was caused by stop.
- clear, in any state:
  - Live counters, snapshot counters and win_cnt go to 0; next state IDLE.
  - No snap_valid is produced.
- Idle detector, active in every state:
  - quiet = &port_empty & ~|flit_wr_o & ~|flit_wr_i.
  - An 8-bit counter increments while quiet, saturating at IDLE_CYC, and resets to 0 on any non-quiet cycle.
  - router_idle = (cnt == IDLE_CYC).
- window_len is sampled only on start and on SNAP reload. Changes mid-window take effect at the next reload.

## Timing
- Reset values: all counters, snapshot buses, snap_valid, running and router_idle are 0; state is IDLE.
- Live-count latency: an event in cycle n is visible in the live count at n+1.
- Snapshot latency: snapshot buses and snap_valid change on the same edge, which ends the SNAP cycle. They hold until the next snapshot or clear.
- With window_len = W ≥ 1, snap_valid pulses every W+1 cycles: W RUN cycles plus 1 SNAP cycle.
- window_len = 1 alternates RUN and SNAP.
- stop in the same cycle as win_cnt == 1 produces a single snapshot and then IDLE.
- start while in RUN is ignored.
- Reset asserted mid-window: outputs clear asynchronously. No snapshot is emitted on reset release.
- router_idle asserts on the edge that ends the IDLE_CYC-th consecutive quiet cycle and deasserts on the edge after the first non-quiet cycle.

## Configuration
- ROUTER_MONITOR_BYPASS_CNT_EN:
  - Defined: the bypass_cnt live and snapshot registers exist and count flit_in_bypassed.
  - Undefined: those registers are not generated, bypass_cnt is tied to 0 and flit_in_bypassed is ignored. Use this for non-SMART builds.

## Test plan
- Saturation: reset, CNTw=4, window_len=0, start, flit_wr_i[0] high for 20 cycles, then stop → flit_in_cnt[3:0] = 15 and one snap_valid pulse.
- Window boundary: window_len=5, flit_wr_o[2] high every cycle → snap_valid every 6 cycles; each snapshot after the first reads 6 (5 RUN + 1 carried SNAP event); the first reads 5.
- Packet and bypass counts: window_len=10, 3 headers on pck_wr_i[1], 4 bypassed flits on port 3 →
  - pck_in_cnt port1 = 3.
  - With the macro defined, bypass_cnt port3 = 4.
  - With the macro undefined, bypass_cnt port3 = 0.
- Priority: clear and stop asserted in the same cycle during RUN → no snap_valid, all outputs 0, state IDLE (running = 0).
- Idle detector: IDLE_CYC=8, all ports quiet → router_idle rises after 8 cycles; a single flit_wr_i pulse drops it on the next edge and restarts the count.
- Reset mid-window: reset low for 1 cycle at cycle 3 of window_len=8 → all outputs 0 immediately; no snap_valid after release until a new start.

Source files
------------

// File: rtl/router_event_monitor.sv
// Per-port saturating event profiler with windowed snapshots and a router idle detector.
// Optional feature macro: ROUTER_MONITOR_BYPASS_CNT_EN (enables SMART bypass counters).

module router_event_monitor_port #(
  parameter int CNTw = 32,
  parameter int NEV  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      run,
  input  logic                      snap,
  input  logic [NEV-1:0]            ev,
  output logic [NEV-1:0][CNTw-1:0]  snap_cnt
);
  localparam logic [CNTw-1:0] CNT_MAX = '1;

  logic [NEV-1:0][CNTw-1:0] live;

  // A SNAP cycle hands the live count over and restarts it with its own events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live     <= '0;
      snap_cnt <= '0;
    end else if (clr) begin
      live     <= '0;
      snap_cnt <= '0;
    end else begin
      for (int e = 0; e < NEV; e++) begin
        if (snap) begin
          snap_cnt[e] <= live[e];
          live[e]     <= CNTw'(ev[e]);
        end else if (run && ev[e] && live[e] != CNT_MAX) begin
          live[e] <= live[e] + 1'b1;
        end
      end
    end
  end
endmodule

module router_event_monitor #(
  parameter int P        = 5,
  parameter int CNTw     = 32,
  parameter int WINw     = 16,
  parameter int IDLE_CYC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [P-1:0]      flit_wr_i,
  input  logic [P-1:0]      pck_wr_i,
  input  logic [P-1:0]      flit_wr_o,
  input  logic [P-1:0]      pck_wr_o,
  input  logic [P-1:0]      flit_in_bypassed,
  input  logic [P-1:0]      port_empty,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [WINw-1:0]   window_len,
  output logic [P*CNTw-1:0] flit_in_cnt,
  output logic [P*CNTw-1:0] pck_in_cnt,
  output logic [P*CNTw-1:0] flit_out_cnt,
  output logic [P*CNTw-1:0] pck_out_cnt,
  output logic [P*CNTw-1:0] bypass_cnt,
  output logic              snap_valid,
  output logic              running,
  output logic              router_idle
);
`ifdef ROUTER_MONITOR_BYPASS_CNT_EN
  localparam int NEV = 5;
`else
  localparam int NEV = 4;
  logic unused_byp;
  assign unused_byp = ^flit_in_bypassed;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SNAP} state_t;

  state_t          state;
  logic [WINw-1:0] win_cnt;
  logic            pend_clr, pend_stop, pend_start, stop_snap;
  logic            c_clr, c_stop, c_start;
  logic            cnt_clr, cnt_run, cnt_snap;

  // Controls seen during SNAP are replayed one cycle later.
  assign c_clr   = clear | pend_clr;
  assign c_stop  = stop  | pend_stop;
  assign c_start = start | pend_start;

  assign cnt_clr  = (state != S_SNAP) && c_clr;
  assign cnt_run  = (state == S_RUN) && !c_clr;
  assign cnt_snap = (state == S_SNAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      win_cnt    <= '0;
      pend_clr   <= 1'b0;
      pend_stop  <= 1'b0;
      pend_start <= 1'b0;
      stop_snap  <= 1'b0;
      snap_valid <= 1'b0;
      running    <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      if (state == S_SNAP) begin
        pend_clr   <= clear;
        pend_stop  <= stop;
        pend_start <= start;
        snap_valid <= 1'b1;
        stop_snap  <= 1'b0;
        if (stop_snap) begin
          state   <= S_IDLE;
          running <= 1'b0;
        end else begin
          state   <= S_RUN;
          running <= 1'b1;
          win_cnt <= window_len;
        end
      end else begin
        pend_clr   <= 1'b0;
        pend_stop  <= 1'b0;
        pend_start <= 1'b0;
        if (c_clr) begin
          state     <= S_IDLE;
          running   <= 1'b0;
          win_cnt   <= '0;
          stop_snap <= 1'b0;
        end else if (state == S_IDLE) begin
          if (c_start) begin
            state   <= S_RUN;
            running <= 1'b1;
            win_cnt <= window_len;
          end
        end else begin
          if (win_cnt != '0) win_cnt <= win_cnt - 1'b1;
          if (c_stop || win_cnt == WINw'(1)) begin
            state     <= S_SNAP;
            running   <= 1'b0;
            stop_snap <= c_stop;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_port
    logic [NEV-1:0]           ev;
    logic [NEV-1:0][CNTw-1:0] sc;
`ifdef ROUTER_MONITOR_BYPASS_CNT_EN
    assign ev = {flit_in_bypassed[i], pck_wr_o[i], flit_wr_o[i], pck_wr_i[i], flit_wr_i[i]};
    assign bypass_cnt[i*CNTw +: CNTw] = sc[4];
`else
    assign ev = {pck_wr_o[i], flit_wr_o[i], pck_wr_i[i], flit_wr_i[i]};
    assign bypass_cnt[i*CNTw +: CNTw] = '0;
`endif
    router_event_monitor_port #(.CNTw(CNTw), .NEV(NEV)) u_port (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .run      (cnt_run),
      .snap     (cnt_snap),
      .ev       (ev),
      .snap_cnt (sc)
    );
    assign flit_in_cnt [i*CNTw +: CNTw] = sc[0];
    assign pck_in_cnt  [i*CNTw +: CNTw] = sc[1];
    assign flit_out_cnt[i*CNTw +: CNTw] = sc[2];
    assign pck_out_cnt [i*CNTw +: CNTw] = sc[3];
  end

  localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYC);

  logic [7:0] idle_cnt;
  logic       quiet;

  assign quiet       = &port_empty & ~|flit_wr_o & ~|flit_wr_i;
  assign router_idle = (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     idle_cnt <= '0;
    else if (!quiet)                idle_cnt <= '0;
    else if (idle_cnt != IDLE_MAX)  idle_cnt <= idle_cnt + 1'b1;
  end
endmodule

// File: tb/tb_router_event_monitor.sv
// Directed bench for router_event_monitor: control table plus multi-cycle corner sequences.
module tb_router_event_monitor;
  localparam int P = 5, CNTw = 4, WINw = 16, IDLE_CYC = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [P-1:0]      flit_wr_i = '0, pck_wr_i = '0, flit_wr_o = '0, pck_wr_o = '0;
  logic [P-1:0]      flit_in_bypassed = '0, port_empty = '0;
  logic              start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [WINw-1:0]   window_len = '0;
  logic [P*CNTw-1:0] flit_in_cnt, pck_in_cnt, flit_out_cnt, pck_out_cnt, bypass_cnt;
  logic              snap_valid, running, router_idle;

  int errors = 0;
  int checks = 0;
  int sv_cnt = 0;

  router_event_monitor #(.P(P), .CNTw(CNTw), .WINw(WINw), .IDLE_CYC(IDLE_CYC)) dut (
    .clk(clk), .reset(reset),
    .flit_wr_i(flit_wr_i), .pck_wr_i(pck_wr_i), .flit_wr_o(flit_wr_o), .pck_wr_o(pck_wr_o),
    .flit_in_bypassed(flit_in_bypassed), .port_empty(port_empty),
    .start(start), .stop(stop), .clear(clear), .window_len(window_len),
    .flit_in_cnt(flit_in_cnt), .pck_in_cnt(pck_in_cnt), .flit_out_cnt(flit_out_cnt),
    .pck_out_cnt(pck_out_cnt), .bypass_cnt(bypass_cnt),
    .snap_valid(snap_valid), .running(running), .router_idle(router_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (snap_valid) sv_cnt <= sv_cnt + 1;

  typedef struct {
    logic       start, stop, clear, fwi0;
    logic       exp_sv, exp_run;
    logic [3:0] exp_fic0;
  } vec_t;

  // window_len = 2 control sequence; each row is one cycle of inputs and the outputs after its edge.
  vec_t vec [16] = '{
    '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2},
    '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1},
    '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2},
    '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] fld(input logic [P*CNTw-1:0] bus, input int i);
    return bus[i*CNTw +: CNTw];
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_fic"}, 32'(flit_in_cnt), 0);
    check({name, "_pic"}, 32'(pck_in_cnt), 0);
    check({name, "_foc"}, 32'(flit_out_cnt), 0);
    check({name, "_poc"}, 32'(pck_out_cnt), 0);
    check({name, "_byp"}, 32'(bypass_cnt), 0);
    check({name, "_sv"}, 32'(snap_valid), 0);
    check({name, "_run"}, 32'(running), 0);
  endtask

  initial begin
    int base;
    logic [3:0] exp_byp;

    // Reset state
    #12;
    check_all_zero("reset");
    check("reset_idle", 32'(router_idle), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Control table
    window_len = 16'd2;
    foreach (vec[k]) begin
      start = vec[k].start; stop = vec[k].stop; clear = vec[k].clear;
      flit_wr_i = {4'b0, vec[k].fwi0};
      tick();
      check($sformatf("tbl%0d_sv", k), 32'(snap_valid), 32'(vec[k].exp_sv));
      check($sformatf("tbl%0d_run", k), 32'(running), 32'(vec[k].exp_run));
      check($sformatf("tbl%0d_fic0", k), 32'(fld(flit_in_cnt, 0)), 32'(vec[k].exp_fic0));
    end
    start = 0; stop = 0; clear = 0; flit_wr_i = '0;
    check_all_zero("clr_prio");

    // Saturation with no automatic windows
    window_len = 16'd0;
    base = sv_cnt;
    start = 1; tick(); start = 0;
    flit_wr_i = 5'b00001;
    repeat (20) tick();
    stop = 1; flit_wr_i = '0; tick(); stop = 0;
    check("sat_run_after_stop", 32'(running), 0);
    tick();
    check("sat_sv", 32'(snap_valid), 1);
    check("sat_fic0", 32'(fld(flit_in_cnt, 0)), 15);
    repeat (4) tick();
    check("sat_pulses", 32'(sv_cnt - base), 1);

    // Window boundary every W+1 cycles
    window_len = 16'd5;
    flit_wr_o = 5'b00100;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("win_sv%0d", k), 32'(snap_valid), 32'(k % 6 == 0));
      if (k == 6)  check("win_first", 32'(fld(flit_out_cnt, 2)), 5);
      if (k == 12) check("win_second", 32'(fld(flit_out_cnt, 2)), 6);
      if (k == 18) check("win_third", 32'(fld(flit_out_cnt, 2)), 6);
    end
    flit_wr_o = '0;
    clear = 1; tick(); clear = 0;
    check_all_zero("win_clr");

    // Packet and bypass counts
    window_len = 16'd10;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 10; k++) begin
      pck_wr_i         = (k < 6 && k % 2 == 0) ? 5'b00010 : 5'b0;
      flit_in_bypassed = (k < 8 && k % 2 == 1) ? 5'b01000 : 5'b0;
      tick();
    end
    pck_wr_i = '0; flit_in_bypassed = '0;
    tick();
`ifdef ROUTER_MONITOR_BYPASS_CNT_EN
    exp_byp = 4'd4;
`else
    exp_byp = 4'd0;
`endif
    check("pkt_sv", 32'(snap_valid), 1);
    check("pkt_pic1", 32'(fld(pck_in_cnt, 1)), 3);
    check("pkt_byp3", 32'(fld(bypass_cnt, 3)), 32'(exp_byp));
    check("pkt_fic0", 32'(fld(flit_in_cnt, 0)), 0);
    clear = 1; tick(); clear = 0;

    // Idle detector
    port_empty = '1;
    flit_wr_i = 5'b00001; tick(); flit_wr_i = '0;
    check("idle_busy", 32'(router_idle), 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("idle_q%0d", k), 32'(router_idle), 32'(k >= 8));
    end
    flit_wr_i = 5'b00010; tick(); flit_wr_i = '0;
    check("idle_drop", 32'(router_idle), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("idle_r%0d", k), 32'(router_idle), 32'(k == 8));
    end
    port_empty = '0;

    // Reset mid-window, starting from a nonzero snapshot
    window_len = 16'd0;
    start = 1; tick(); start = 0;
    flit_wr_i = 5'b00001;
    repeat (2) tick();
    stop = 1; tick(); stop = 0;
    flit_wr_i = '0; tick();
    check("pre_rst_fic0", 32'(fld(flit_in_cnt, 0)), 3);
    window_len = 16'd8;
    start = 1; tick(); start = 0;
    flit_wr_i = 5'b00001;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    reset = 1'b1;
    base = sv_cnt;
    repeat (12) tick();
    check("rst_no_snap", 32'(sv_cnt - base), 0);
    check("rst_not_running", 32'(running), 0);
    start = 1; tick(); start = 0;
    repeat (8) tick();
    flit_wr_i = '0;
    tick();
    check("rst_new_sv", 32'(snap_valid), 1);
    check("rst_new_fic0", 32'(fld(flit_in_cnt, 0)), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
